// File: rtl/natv_bus_arbiter.sv
// ---------------------------------------------------------------------------
// natv_bus_arbiter
//
// Round-robin arbiter that shares one native valid/ready memory-bus slave
// port between NUM_MST requesters (e.g. CPU core plus a DMA/debug master).
// A per-transaction watchdog forces completion with ERR_RDATA when the slave
// does not answer within TIMEOUT_CYC busy cycles, so a dead slave cannot
// hang a master.
//
// Ports
//   clk_i, rst_i    clock, asynchronous active-high reset
//   mst_valid_i     per-master request valid
//   mst_addr_i      packed addresses, master k at [32k+31:32k]
//   mst_wdata_i     packed write data
//   mst_wstrb_i     packed byte strobes, 4'b0000 = read
//   mst_rdata_o     read data, broadcast to every master
//   mst_ready_o     per-master completion, one-hot or zero
//   slv_*_o         request towards the slave (valid/addr/wdata/wstrb)
//   slv_rdata_i     slave read data
//   slv_ready_i     slave completion
//   grant_o         one-hot current owner, zero while idle
//   timeout_o       one-cycle pulse on a watchdog-forced completion
// ---------------------------------------------------------------------------
module natv_bus_arbiter #(
    parameter int          NUM_MST     = 2,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_MST-1:0]      mst_valid_i,
    input  logic [NUM_MST*32-1:0]   mst_addr_i,
    input  logic [NUM_MST*32-1:0]   mst_wdata_i,
    input  logic [NUM_MST*4-1:0]    mst_wstrb_i,
    output logic [31:0]             mst_rdata_o,
    output logic [NUM_MST-1:0]      mst_ready_o,
    output logic                    slv_valid_o,
    output logic [31:0]             slv_addr_o,
    output logic [31:0]             slv_wdata_o,
    output logic [3:0]              slv_wstrb_o,
    input  logic [31:0]             slv_rdata_i,
    input  logic                    slv_ready_i,
    output logic [NUM_MST-1:0]      grant_o,
    output logic                    timeout_o
);

    localparam int IW = $clog2(NUM_MST);
    // A disabled watchdog still keeps a 1-bit timer so no zero-width vector exists.
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [NUM_MST-1:0] ONE_HOT0 = {{(NUM_MST-1){1'b0}}, 1'b1};

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t               r_state;
    logic [IW-1:0]        r_gidx;
    logic [NUM_MST-1:0]   r_grant;
    logic [IW-1:0]        r_last;
    logic [TW-1:0]        r_timer;

    // Per-master views of the packed request buses.
    logic [NUM_MST-1:0][31:0] w_addr;
    logic [NUM_MST-1:0][31:0] w_wdata;
    logic [NUM_MST-1:0][3:0]  w_wstrb;

    assign w_addr  = mst_addr_i;
    assign w_wdata = mst_wdata_i;
    assign w_wstrb = mst_wstrb_i;

    // -----------------------------------------------------------------------
    // Round-robin pick: first requester searching upward from r_last+1,
    // wrapping modulo NUM_MST. The previous owner is visited last, which is
    // what keeps an immediately re-requesting master from starving others.
    // -----------------------------------------------------------------------
    logic          w_found;
    logic [IW-1:0] w_pick;

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            idx = (int'(r_last) + i) % NUM_MST;
            if (!w_found && mst_valid_i[idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(idx);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Busy-phase decode
    // -----------------------------------------------------------------------
    logic w_busy;
    logic w_gvalid;
    logic w_done;
    logic w_tmo;
    logic w_end;

    assign w_busy   = (r_state == ST_BUSY);
    assign w_gvalid = mst_valid_i[r_gidx];
    // Slave completion always wins over an expiring timer in the same cycle.
    assign w_done   = w_busy & slv_ready_i;
    // A withdrawn request is not timed out; it simply ends the ownership.
    assign w_tmo    = (TIMEOUT_CYC > 0) & w_busy & w_gvalid & ~slv_ready_i
                    & (r_timer == TMR_LAST);
    assign w_end    = w_done | w_tmo | (w_busy & ~w_gvalid);

    // -----------------------------------------------------------------------
    // Outputs. The slave request is a pure mux of the owner's fields so the
    // only added latency is the single arbitration cycle.
    // -----------------------------------------------------------------------
    assign slv_valid_o = w_busy & w_gvalid & ~w_tmo;
    assign slv_addr_o  = w_busy ? w_addr[r_gidx]  : 32'h0;
    assign slv_wdata_o = w_busy ? w_wdata[r_gidx] : 32'h0;
    assign slv_wstrb_o = w_busy ? w_wstrb[r_gidx] : 4'h0;

    assign mst_ready_o = (w_done | w_tmo) ? r_grant : '0;
    assign mst_rdata_o = w_tmo ? ERR_RDATA : slv_rdata_i;
    assign timeout_o   = w_tmo;
    assign grant_o     = r_grant;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gidx  <= '0;
            r_grant <= '0;
            r_last  <= IW'(NUM_MST - 1);   // master 0 wins the first round
            r_timer <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gidx  <= w_pick;
                        r_grant <= ONE_HOT0 << w_pick;
                        r_timer <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_end) begin
                        r_last  <= r_gidx;
                        r_grant <= '0;
                        r_state <= ST_IDLE;
                    end else if (r_timer != TMR_MAX) begin
                        // Saturating count; never wraps back into range.
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_natv_bus_arbiter.sv
module tb_natv_bus_arbiter;

    localparam int NM  = 2;
    localparam int TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_valid = '0;
    logic [NM-1:0][31:0] m_addr  = '0;
    logic [NM-1:0][31:0] m_wdata = '0;
    logic [NM-1:0][3:0]  m_wstrb = '0;
    logic [31:0]       m_rdata;
    logic [NM-1:0]     m_ready;
    logic              s_valid;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_rdata = '0;
    logic              s_ready = 1'b0;
    logic [NM-1:0]     grant;
    logic              tmo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    natv_bus_arbiter #(.NUM_MST(NM), .TIMEOUT_CYC(TMO), .ERR_RDATA(ERR)) dut (
        .clk_i(clk), .rst_i(rst),
        .mst_valid_i(m_valid), .mst_addr_i(m_addr), .mst_wdata_i(m_wdata),
        .mst_wstrb_i(m_wstrb), .mst_rdata_o(m_rdata), .mst_ready_o(m_ready),
        .slv_valid_o(s_valid), .slv_addr_o(s_addr), .slv_wdata_o(s_wdata),
        .slv_wstrb_o(s_wstrb), .slv_rdata_i(s_rdata), .slv_ready_i(s_ready),
        .grant_o(grant), .timeout_o(tmo)
    );

    typedef struct {
        logic [1:0]  v;
        logic        sr;
        logic [31:0] srd;
        logic [1:0]  g;
        logic        svld;
        logic [1:0]  rdy;
        logic        to;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [1:0] v, input logic sr, input logic [31:0] srd,
                                input logic [1:0] g, input logic svld, input logic [1:0] rdy,
                                input logic to, input logic [31:0] rd);
        vec_t e;
        e.v = v; e.sr = sr; e.srd = srd; e.g = g; e.svld = svld;
        e.rdy = rdy; e.to = to; e.rd = rd;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int owner, last, cnt, k, ow;
        logic [1:0] pend, e_rdy;
        logic e_tmo, sr;
        logic [31:0] srd;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #2;
        chk("rst grant", grant, 0);
        chk("rst slv_valid", s_valid, 0);
        chk("rst ready", m_ready, 0);
        chk("rst timeout", tmo, 0);
        chk("rst slv_addr", s_addr, 0);
        chk("rst rdata", m_rdata, 0);

        m_addr[0] = 32'h0000_1000; m_wdata[0] = 32'h0; m_wstrb[0] = 4'h0;
        m_addr[1] = 32'h2000_0004; m_wdata[1] = 32'hA5A5_A5A5; m_wstrb[1] = 4'b0011;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- directed table ----------------
        // single read by master 0, slave answers on third busy cycle
        add(2'b01, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        add(2'b01, 0, 0, 2'b01, 1, 2'b00, 0, 0);
        add(2'b01, 0, 0, 2'b01, 1, 2'b00, 0, 0);
        add(2'b01, 1, 32'h1234_5678, 2'b01, 1, 2'b01, 0, 32'h1234_5678);
        add(2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        // both masters requesting: owners alternate 1,0,1,0
        for (int t = 0; t < 4; t++) begin
            logic [1:0] gg;
            gg = (t % 2 == 0) ? 2'b10 : 2'b01;
            add(2'b11, 0, 0, 2'b00, 0, 2'b00, 0, 0);
            add(2'b11, 0, 0, gg, 1, 2'b00, 0, 0);
            add(2'b11, 1, 32'h1111_0000 + t, gg, 1, gg, 0, 32'h1111_0000 + t);
        end
        // slave silent: forced completion on the 8th busy cycle
        add(2'b01, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        for (int t = 0; t < TMO - 1; t++) add(2'b01, 0, 0, 2'b01, 1, 2'b00, 0, 0);
        add(2'b01, 0, 32'h7777_7777, 2'b01, 0, 2'b01, 1, ERR);
        // slave ready exactly on the 8th busy cycle: normal completion wins
        add(2'b01, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        for (int t = 0; t < TMO - 1; t++) add(2'b01, 0, 0, 2'b01, 1, 2'b00, 0, 0);
        add(2'b01, 1, 32'h5555_AAAA, 2'b01, 1, 2'b01, 0, 32'h5555_AAAA);
        add(2'b00, 0, 0, 2'b00, 0, 2'b00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            m_valid = tbl[i].v; s_ready = tbl[i].sr; s_rdata = tbl[i].srd;
            #2;
            chk($sformatf("tbl%0d grant", i), grant, tbl[i].g);
            chk($sformatf("tbl%0d slv_valid", i), s_valid, tbl[i].svld);
            chk($sformatf("tbl%0d ready", i), m_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d timeout", i), tmo, tbl[i].to);
            if (tbl[i].rdy != 0) chk($sformatf("tbl%0d rdata", i), m_rdata, tbl[i].rd);
            if (tbl[i].svld) begin
                ow = tbl[i].g[1] ? 1 : 0;
                chk($sformatf("tbl%0d addr", i), s_addr, m_addr[ow]);
                chk($sformatf("tbl%0d wdata", i), s_wdata, m_wdata[ow]);
                chk($sformatf("tbl%0d wstrb", i), s_wstrb, m_wstrb[ow]);
            end
        end

        // ---------------- reset in the middle of a master-1 transfer ----------------
        @(negedge clk); m_valid = 2'b10; s_ready = 0; s_rdata = 0;
        @(negedge clk); #2;
        chk("mid grant m1", grant, 2'b10);
        chk("mid slv_valid", s_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async grant", grant, 0);
        chk("async slv_valid", s_valid, 0);
        chk("async ready", m_ready, 0);
        chk("async timeout", tmo, 0);
        chk("async addr", s_addr, 0);
        @(negedge clk); rst = 1'b0; m_valid = 2'b11;
        #2 chk("post-rst idle", grant, 0);
        @(negedge clk); #2;
        chk("post-rst owner m0", grant, 2'b01);
        s_ready = 1'b1; #1;
        chk("post-rst ready", m_ready, 2'b01);
        @(negedge clk); m_valid = 0; s_ready = 0;

        // ---------------- randomized phase against a transaction model ----------------
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        owner = -1; last = NM - 1; cnt = 0; pend = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            sr  = ($urandom_range(0, 9) < ((c < 400) ? 3 : 1));
            srd = $urandom;
            m_valid = pend; s_ready = sr; s_rdata = srd;
            #2;
            e_tmo = (owner >= 0) && !sr && (cnt == TMO - 1);
            e_rdy = '0;
            if (owner >= 0 && (sr || e_tmo)) e_rdy[owner] = 1'b1;
            chk("rnd grant", grant, (owner >= 0) ? (32'd1 << owner) : 32'd0);
            chk("rnd slv_valid", s_valid, (owner >= 0) && !e_tmo);
            chk("rnd ready", m_ready, e_rdy);
            chk("rnd timeout", tmo, e_tmo);
            chk("rnd rdata", m_rdata, e_tmo ? ERR : srd);
            if (owner >= 0) begin
                chk("rnd addr", s_addr, m_addr[owner]);
                chk("rnd wdata", s_wdata, m_wdata[owner]);
                chk("rnd wstrb", s_wstrb, m_wstrb[owner]);
            end
            // advance the model for this clock edge
            if (owner < 0) begin
                for (int i = 1; i <= NM; i++) begin
                    k = (last + i) % NM;
                    if (owner < 0 && pend[k]) begin owner = k; cnt = 0; end
                end
            end else if (sr || e_tmo) begin
                last = owner; owner = -1;
            end else begin
                cnt++;
            end
            // masters: hold while pending, maybe issue a fresh request after done/idle
            for (int m = 0; m < NM; m++) begin
                if (e_rdy[m] || !pend[m]) begin
                    pend[m] = ($urandom_range(0, 2) != 0);
                    if (pend[m]) begin
                        m_addr[m]  = $urandom & 32'hFFFF_FFFC;
                        m_wdata[m] = $urandom;
                        m_wstrb[m] = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
